// File: rtl/pat_str_pkg.sv
// Shared types and constants for the pattern string generator.
package pat_str_pkg;

  localparam int unsigned STR_W     = 64;
  localparam int unsigned PAT_W     = 4;
  localparam int unsigned NUM_BYTES = 8;
  localparam int unsigned MAX_OFS   = 60;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StInsert,
    StSend,
    StDone
  } state_e;

  // Byte 0 is the most-significant byte, so its lsb sits at bit 56.
  function automatic logic [5:0] byte_lsb(input logic [2:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/pat_lfsr8.sv
// 8-bit Fibonacci LFSR filler source: shift left, feedback b7^b5^b4^b3 into bit 0.
module pat_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= 8'h00;
    end else if (load_i) begin
      // An all-zero state would lock up, so a zero seed maps to 1.
      state_q <= (seed_i == 8'h00) ? 8'h01 : seed_i;
    end else if (step_i) begin
      state_q <= {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pat_str_gen.sv
// Builds a 64-bit string (filler plus injected 4-bit patterns) and streams it out bytewise.
// Define PATGEN_LFSR_EN to take filler bytes from an LFSR instead of zeros.
module pat_str_gen
  import pat_str_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [PAT_W-1:0]  pat_i,
  input  logic [STR_W-1:0]  pos_mask_i,
  input  logic [7:0]        seed_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [6:0]        ins_cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [5:0] LastOfs  = 6'(MAX_OFS);
  localparam logic [2:0] LastByte = 3'(NUM_BYTES - 1);

  state_e              state_q;
  logic [5:0]          cnt_q;
  logic [STR_W-1:0]    str_q;
  logic [PAT_W-1:0]    pat_q;
  logic [STR_W-1:0]    mask_q;
  logic [ADDR_W-1:0]   base_q;
  logic [6:0]          ins_cnt_q;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;
  logic                busy_q;
  logic                done_q;

  logic [7:0]          filler;
  logic [STR_W-1:0]    str_ins;
  logic                ins_hit;
  logic [2:0]          nxt_idx;

`ifdef PATGEN_LFSR_EN
  logic lfsr_load;
  logic lfsr_step;

  assign lfsr_load = start_i && (state_q == StIdle);
  assign lfsr_step = (state_q == StFill);

  pat_lfsr8 u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (lfsr_load),
    .seed_i  (seed_i),
    .step_i  (lfsr_step),
    .state_o (filler)
  );
`else
  logic unused_seed;

  assign unused_seed = ^seed_i;
  assign filler      = 8'h00;
`endif

  assign ins_hit = mask_q[cnt_q];
  assign nxt_idx = cnt_q[2:0] + 3'd1;

  // String after this cycle's insertion; also feeds byte 0 on the INSERT->SEND edge.
  always_comb begin
    str_ins = str_q;
    if (ins_hit) begin
      str_ins[cnt_q +: PAT_W] = pat_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      str_q      <= '0;
      pat_q      <= '0;
      mask_q     <= '0;
      base_q     <= '0;
      ins_cnt_q  <= 7'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            pat_q     <= pat_i;
            mask_q    <= pos_mask_i;
            base_q    <= base_addr_i;
            ins_cnt_q <= 7'd0;
            cnt_q     <= 6'd0;
            busy_q    <= 1'b1;
            state_q   <= StFill;
          end
        end
        StFill: begin
          str_q[byte_lsb(cnt_q[2:0]) +: 8] <= filler;
          if (cnt_q[2:0] == LastByte) begin
            cnt_q   <= 6'd0;
            state_q <= StInsert;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StInsert: begin
          str_q <= str_ins;
          if (ins_hit) begin
            ins_cnt_q <= ins_cnt_q + 7'd1;
          end
          if (cnt_q == LastOfs) begin
            cnt_q      <= 6'd0;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= base_q;
            wr_data_q  <= str_ins[STR_W-1 -: 8];
            state_q    <= StSend;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StSend: begin
          if (wr_ready_i) begin
            if (cnt_q[2:0] == LastByte) begin
              wr_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              cnt_q     <= cnt_q + 6'd1;
              wr_addr_q <= base_q + ADDR_W'(nxt_idx);
              wr_data_q <= str_q[byte_lsb(nxt_idx) +: 8];
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign ins_cnt_o  = ins_cnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
